// File: rtl/hazard_fwd_ctrl.sv
// Operand forwarding selects, load-use hazard detection and a load-latency stall FSM.
// Optional saturating stall-cycle counter is built only when HAZ_STALL_CNT_EN is defined.
module hazard_fwd_ctrl #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ifid_rs,
   input  logic [REG_AW-1:0] ifid_rt,
   input  logic              ifid_use_rt,
   input  logic [REG_AW-1:0] idex_rs,
   input  logic [REG_AW-1:0] idex_rt,
   input  logic              idex_memread,
   input  logic              exmem_regwrite,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic              memwb_regwrite,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              flush,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic [CNT_W-1:0]  stall_count
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       haz;
   logic       stall;

   // The younger EX/MEM result wins over MEM/WB; register 0 never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              ex_we,
      input logic [REG_AW-1:0] ex_rd,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (ex_we && (ex_rd != '0) && (ex_rd == src)) begin
         sel = 2'b10;
      end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign forward_a = fwd_sel(idex_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
   assign forward_b = fwd_sel(idex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);

   assign haz = idex_memread && (idex_rt != '0) &&
                ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));

   // Stall is combinational so the detection cycle itself counts toward LOAD_LAT.
   assign stall       = !flush && ((state_q == HOLD) || haz);
   assign pc_write    = !stall;
   assign ifid_write  = !stall;
   assign idex_bubble = stall;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end else if (state_q == HOLD) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = IDLE;
         end
      end else if (haz && (LOAD_LAT > 1)) begin
         state_d = HOLD;
         cnt_d   = 4'(LOAD_LAT - 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZ_STALL_CNT_EN
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: four instances (LOAD_LAT 1,3,4,5) share one stimulus stream
// and are compared against a remaining-stall-cycles reference model.
module tb_hazard_fwd_ctrl;

   localparam int N = 4;
   localparam int LATS[N] = '{1, 3, 4, 5};
   localparam int CWS[N]  = '{3, 16, 16, 16};

   logic       clk;
   logic       rst_n;
   logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
   logic       ifid_use_rt, idex_memread, exmem_regwrite, memwb_regwrite, flush;

   logic [1:0]  fa[N];
   logic [1:0]  fb[N];
   logic        pcw[N];
   logic        ifw[N];
   logic        bub[N];
   logic [15:0] sc[N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int CW = CWS[g];
      logic [CW-1:0] sc_l;
      hazard_fwd_ctrl #(.REG_AW(5), .LOAD_LAT(LATS[g]), .CNT_W(CW)) u_dut (
         .clk            (clk),
         .rst_n          (rst_n),
         .ifid_rs        (ifid_rs),
         .ifid_rt        (ifid_rt),
         .ifid_use_rt    (ifid_use_rt),
         .idex_rs        (idex_rs),
         .idex_rt        (idex_rt),
         .idex_memread   (idex_memread),
         .exmem_regwrite (exmem_regwrite),
         .exmem_rd       (exmem_rd),
         .memwb_regwrite (memwb_regwrite),
         .memwb_rd       (memwb_rd),
         .flush          (flush),
         .forward_a      (fa[g]),
         .forward_b      (fb[g]),
         .pc_write       (pcw[g]),
         .ifid_write     (ifw[g]),
         .idex_bubble    (bub[g]),
         .stall_count    (sc_l)
      );
      assign sc[g] = 16'(sc_l);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: stall cycles still owed after the current one, plus stall tally.
   int rem[N];
   int cnt[N];

   typedef struct {
      logic       exw;
      logic [4:0] exrd;
      logic       mww;
      logic [4:0] mwrd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] ea;
      logic [1:0] eb;
   } fvec_t;

   fvec_t fv[9];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit haz_m();
      return idex_memread && (idex_rt != 0) &&
             ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));
   endfunction

   function automatic logic [1:0] fwd_m(input logic [4:0] src);
      if (exmem_regwrite && exmem_rd != 0 && exmem_rd == src) return 2'b10;
      if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit stall_m(input int g);
      if (flush) return 1'b0;
      if (rem[g] > 0) return 1'b1;
      return haz_m();
   endfunction

   function automatic int exp_sc(input int g);
`ifdef HAZ_STALL_CNT_EN
      return cnt[g];
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      for (int g = 0; g < N; g++) begin
         rem[g] = 0;
         cnt[g] = 0;
      end
   endtask

   task automatic model_edge();
      bit s;
      for (int g = 0; g < N; g++) begin
         if (!rst_n) begin
            rem[g] = 0;
            cnt[g] = 0;
         end else begin
            s = stall_m(g);
            if (s && cnt[g] < (1 << CWS[g]) - 1) cnt[g]++;
            if (flush) rem[g] = 0;
            else if (rem[g] > 0) rem[g]--;
            else if (haz_m()) rem[g] = LATS[g] - 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      bit s;
      for (int g = 0; g < N; g++) begin
         s = stall_m(g);
         chk($sformatf("%s pc_write[%0d]", tag, g), pcw[g], !s);
         chk($sformatf("%s ifid_write[%0d]", tag, g), ifw[g], !s);
         chk($sformatf("%s idex_bubble[%0d]", tag, g), bub[g], s);
         chk($sformatf("%s forward_a[%0d]", tag, g), fa[g], fwd_m(idex_rs));
         chk($sformatf("%s forward_b[%0d]", tag, g), fb[g], fwd_m(idex_rt));
         chk($sformatf("%s stall_count[%0d]", tag, g), sc[g], exp_sc(g));
      end
   endtask

   // Called just after a rising edge; checks mid-cycle, then advances one clock.
   task automatic tick(input string tag);
      #4;
      check_all(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      ifid_rs = 0; ifid_rt = 0; ifid_use_rt = 0;
      idex_rs = 0; idex_rt = 0; idex_memread = 0;
      exmem_regwrite = 0; exmem_rd = 0;
      memwb_regwrite = 0; memwb_rd = 0;
      flush = 0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic set_loaduse();
      idex_memread = 1; idex_rt = 5; ifid_rs = 5;
   endtask

   initial begin
      int run[N];
      clear_inputs();
      rst_n = 1'b0;
      model_reset();

      fv[0] = '{1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3, 2'b10, 2'b10};
      fv[1] = '{1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3, 2'b01, 2'b01};
      fv[2] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd3, 5'd3, 2'b00, 2'b00};
      fv[3] = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
      fv[4] = '{1'b1, 5'd4, 1'b1, 5'd6, 5'd4, 5'd6, 2'b10, 2'b01};
      fv[5] = '{1'b1, 5'd6, 1'b1, 5'd4, 5'd4, 5'd6, 2'b01, 2'b10};
      fv[6] = '{1'b1, 5'd0, 1'b1, 5'd2, 5'd0, 5'd2, 2'b00, 2'b01};
      fv[7] = '{1'b0, 5'd5, 1'b0, 5'd5, 5'd5, 5'd5, 2'b00, 2'b00};
      fv[8] = '{1'b1, 5'd7, 1'b0, 5'd7, 5'd7, 5'd1, 2'b10, 2'b00};

      // Reset state, and combinational hazard still visible while in reset.
      #3;
      for (int g = 0; g < N; g++) begin
         chk($sformatf("rst pc_write[%0d]", g), pcw[g], 1);
         chk($sformatf("rst idex_bubble[%0d]", g), bub[g], 0);
         chk($sformatf("rst stall_count[%0d]", g), sc[g], 0);
      end
      set_loaduse();
      #1;
      for (int g = 0; g < N; g++) chk($sformatf("rst haz pc_write[%0d]", g), pcw[g], 0);
      clear_inputs();

      // Forwarding table, applied while reset is still asserted.
      for (int i = 0; i < 9; i++) begin
         exmem_regwrite = fv[i].exw; exmem_rd = fv[i].exrd;
         memwb_regwrite = fv[i].mww; memwb_rd = fv[i].mwrd;
         idex_rs = fv[i].rs; idex_rt = fv[i].rt;
         #1;
         for (int g = 0; g < N; g++) begin
            chk($sformatf("fwd%0d forward_a[%0d]", i, g), fa[g], fv[i].ea);
            chk($sformatf("fwd%0d forward_b[%0d]", i, g), fb[g], fv[i].eb);
         end
      end
      clear_inputs();

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick("idle");

      // Single load-use: each instance stalls exactly LOAD_LAT consecutive cycles.
      for (int g = 0; g < N; g++) run[g] = 0;
      set_loaduse();
      for (int c = 0; c < 8; c++) begin
         if (c == 1) clear_inputs();
         #4;
         for (int g = 0; g < N; g++) if (!pcw[g]) run[g]++;
         check_all("loaduse");
         @(posedge clk);
         model_edge();
         #1;
      end
      for (int g = 0; g < N; g++) begin
         chk($sformatf("loaduse stall cycles[%0d]", g), run[g], LATS[g]);
`ifdef HAZ_STALL_CNT_EN
         chk($sformatf("loaduse stall_count[%0d]", g), sc[g], LATS[g]);
`else
         chk($sformatf("loaduse stall_count[%0d]", g), sc[g], 0);
`endif
      end

      // Rt gating, purely combinational.
      idex_memread = 1; idex_rt = 7; ifid_rt = 7; ifid_rs = 2; ifid_use_rt = 0;
      #1;
      chk("rt gated off pc_write", pcw[0], 1);
      ifid_use_rt = 1;
      #1;
      chk("rt gated on pc_write", pcw[0], 0);
      chk("rt gated on idex_bubble", bub[0], 1);
      clear_inputs();
      #1;

      // Flush in the second stall cycle of LOAD_LAT=4.
      pulse_reset();
      set_loaduse();
      tick("flush c0");
      clear_inputs();
      flush = 1;
      #4;
      chk("flush hold pc_write[2]", pcw[2], 1);
      check_all("flush c1");
      @(posedge clk); model_edge(); #1;
      flush = 0;
      #4;
      for (int g = 0; g < N; g++) chk($sformatf("post flush pc_write[%0d]", g), pcw[g], 1);
`ifdef HAZ_STALL_CNT_EN
      chk("flush stall_count[2]", sc[2], 1);
`else
      chk("flush stall_count[2]", sc[2], 0);
`endif
      @(posedge clk); model_edge(); #1;
      // Flush coincident with a hazard in IDLE.
      set_loaduse();
      flush = 1;
      tick("flush+haz");
      clear_inputs();
      #4;
      for (int g = 0; g < N; g++) chk($sformatf("flush+haz next pc_write[%0d]", g), pcw[g], 1);
      @(posedge clk); model_edge(); #1;

      // Asynchronous reset in the second HOLD cycle of LOAD_LAT=5.
      pulse_reset();
      set_loaduse();
      tick("rsthold c0");
      clear_inputs();
      tick("rsthold c1");
      #4;
      chk("rsthold before pc_write[3]", pcw[3], 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rsthold async pc_write[3]", pcw[3], 1);
      chk("rsthold async stall_count[3]", sc[3], 0);
      #1;
      rst_n = 1'b1;
      @(posedge clk); model_edge(); #1;
      for (int c = 0; c < 3; c++) begin
         #4;
         chk("rsthold after pc_write[3]", pcw[3], 1);
         check_all("rsthold after");
         @(posedge clk); model_edge(); #1;
      end

      // Randomized traffic against the model; the CNT_W=3 instance saturates.
      for (int c = 0; c < 3000; c++) begin
         ifid_rs        = 5'($urandom_range(0, 3));
         ifid_rt        = 5'($urandom_range(0, 3));
         ifid_use_rt    = 1'($urandom);
         idex_rs        = 5'($urandom_range(0, 3));
         idex_rt        = 5'($urandom_range(0, 3));
         idex_memread   = 1'($urandom);
         exmem_regwrite = 1'($urandom);
         exmem_rd       = 5'($urandom_range(0, 3));
         memwb_regwrite = 1'($urandom);
         memwb_rd       = 5'($urandom_range(0, 3));
         flush          = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all("rand rst");
            rst_n = 1'b1;
         end
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
